// File: rtl/serial_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_tx_pkg
//   Shared serial-link constants. The transmitter and the companion receiver
//   both take their bit period from SERIAL_CLK_PER_BIT, so there is exactly
//   one baud definition for the whole link.
// -----------------------------------------------------------------------------
package serial_tx_pkg;

   // Clocks per serial bit for the link (both ends).
   localparam int unsigned SERIAL_CLK_PER_BIT = 50;

endpackage : serial_tx_pkg

// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
//   UART transmitter, 8N1, LSB first, CLK_PER_BIT clocks per bit.
//
// Ports:
//   clk       in   single clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   tx        out  serial line (registered), idles high
//   block     in   flow control from the consumer; no new frame starts while
//                  its one-cycle-delayed copy is high
//   busy      out  high when a byte would not be accepted
//   data      in   byte to send, sampled only on the acceptance cycle
//   new_data  in   one-cycle strobe
//
// Handshake: a byte is accepted on a rising edge where new_data && !busy.
//   busy depends only on registers, so the sender may look at busy in the
//   same cycle it drives new_data. A strobe while busy is silently dropped.
// -----------------------------------------------------------------------------
module serial_tx
   import serial_tx_pkg::*;
#(
   parameter int CLK_PER_BIT = SERIAL_CLK_PER_BIT,
   parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
   input  logic       clk,
   input  logic       rst,
   output logic       tx,
   input  logic       block,
   output logic       busy,
   input  logic [7:0] data,
   input  logic       new_data
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START_BIT = 2'd1,
      DATA      = 2'd2,
      STOP_BIT  = 2'd3
   } state_t;

   localparam logic [CTR_SIZE-1:0] CTR_LAST = CTR_SIZE'(CLK_PER_BIT - 1);

   state_t              state_q, state_d;
   logic [CTR_SIZE-1:0] ctr_q, ctr_d;
   logic [2:0]          bit_idx_q, bit_idx_d;
   logic [7:0]          shift_q, shift_d;
   logic                tx_q, tx_d;
   logic                block_q, block_d;

   logic                bit_end;

   assign busy    = block_q || (state_q != IDLE);
   assign tx      = tx_q;
   assign bit_end = (ctr_q == CTR_LAST);

   always_comb begin
      state_d   = state_q;
      ctr_d     = ctr_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      block_d   = block;

      case (state_q)
         IDLE: begin
            ctr_d     = '0;
            bit_idx_d = '0;
            if (new_data && !busy) begin
               shift_d = data;
               state_d = START_BIT;
            end
         end
         START_BIT: begin
            ctr_d = ctr_q + 1'b1;
            if (bit_end) begin
               ctr_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            ctr_d = ctr_q + 1'b1;
            if (bit_end) begin
               ctr_d     = '0;
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP_BIT;
               end
            end
         end
         STOP_BIT: begin
            ctr_d = ctr_q + 1'b1;
            if (bit_end) begin
               ctr_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // The line level is derived from the next state so that tx changes on
      // the same edge as the state it belongs to (tx falls on the accepting
      // edge, not one cycle later).
      case (state_d)
         START_BIT: tx_d = 1'b0;
         DATA:      tx_d = shift_d[0];
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ctr_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         block_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctr_q     <= ctr_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         block_q   <= block_d;
      end
   end

endmodule : serial_tx

// File: tb/tb_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_tx
//   Directed bench for serial_tx with CLK_PER_BIT = 4. Inputs are driven and
//   outputs sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_serial_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx;
   logic       block;
   logic       busy;
   logic [7:0] data;
   logic       new_data;

   int n_cmp    = 0;
   int n_err    = 0;
   int cyc      = 0;
   int fall_cyc = 0;
   int prev_fall;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_tx #(.CLK_PER_BIT(CPB)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx       (tx),
      .block    (block),
      .busy     (busy),
      .data     (data),
      .new_data (new_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Caller has just driven new_data=1 with the byte at a falling edge.
   // Walks n_samp cycles of the frame, checking tx against exp_line (bit 0 is
   // the start bit) and busy high, decoding the byte at bit centres.
   // act_kind: 0 none, 1 strobe 0x3C, 2 raise block, 3 assert rst (at act_at).
   task automatic check_frame(input string tag, input logic [7:0] exp_byte,
                              input logic [9:0] exp_line, input int n_samp,
                              input int act_at, input int act_kind,
                              input logic exp_busy_end);
      logic [7:0] rx;
      rx = '0;
      @(negedge clk);
      new_data = 1'b0;
      data     = ~exp_byte;
      fall_cyc = cyc;
      for (int i = 0; i < n_samp; i++) begin
         if (act_kind == 1 && i == act_at + 1) new_data = 1'b0;
         check({tag, "_tx"}, 32'(tx), 32'(exp_line[i / CPB]));
         check({tag, "_busy"}, 32'(busy), 32'd1);
         if ((i % CPB) == 2 && (i / CPB) >= 1 && (i / CPB) <= 8)
            rx[(i / CPB) - 1] = tx;
         if (i == act_at) begin
            case (act_kind)
               1: begin new_data = 1'b1; data = 8'h3C; end
               2: block = 1'b1;
               3: rst = 1'b1;
               default: ;
            endcase
         end
         @(negedge clk);
      end
      if (n_samp == 10 * CPB) begin
         check({tag, "_rx"}, 32'(rx), 32'(exp_byte));
         check({tag, "_busy_end"}, 32'(busy), 32'(exp_busy_end));
         check({tag, "_tx_end"}, 32'(tx), 32'd1);
      end
   endtask

   initial begin
      rst      = 1'b1;
      block    = 1'b0;
      new_data = 1'b0;
      data     = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      // Idle after reset
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_tx", 32'(tx), 32'd1);
         check("idle_busy", 32'(busy), 32'd0);
      end

      // Single frame 0xA5
      data = 8'hA5; new_data = 1'b1;
      check_frame("a5", 8'hA5, 10'b1101001010, 40, -1, 0, 1'b0);

      // Back-to-back 0x00 then 0xFF, each strobed on the first busy=0 cycle
      data = 8'h00; new_data = 1'b1;
      check_frame("b2b_00", 8'h00, 10'b1000000000, 40, -1, 0, 1'b0);
      prev_fall = fall_cyc;
      data = 8'hFF; new_data = 1'b1;
      check_frame("b2b_ff", 8'hFF, 10'b1111111110, 40, -1, 0, 1'b0);
      check("b2b_pitch", 32'(fall_cyc - prev_fall), 32'd41);

      // Strobe of 0x3C mid-frame is ignored
      data = 8'h0F; new_data = 1'b1;
      check_frame("ign", 8'h0F, 10'b1000011110, 40, 15, 1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("ign_idle_tx", 32'(tx), 32'd1);
         check("ign_idle_busy", 32'(busy), 32'd0);
         @(negedge clk);
      end

      // block raised during bit 3 of 0x55
      data = 8'h55; new_data = 1'b1;
      check_frame("blk", 8'h55, 10'b1010101010, 40, 17, 2, 1'b1);
      data = 8'h12; new_data = 1'b1;
      @(negedge clk);
      new_data = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("blk_drop_tx", 32'(tx), 32'd1);
         check("blk_drop_busy", 32'(busy), 32'd1);
         @(negedge clk);
      end
      block = 1'b0;
      check("blk_hold", 32'(busy), 32'd1);
      @(negedge clk);
      check("blk_release", 32'(busy), 32'd0);
      data = 8'h12; new_data = 1'b1;
      check_frame("blk_12", 8'h12, 10'b1000100100, 40, -1, 0, 1'b0);

      // Reset during bit 5 of 0xF0
      data = 8'hF0; new_data = 1'b1;
      check_frame("rstf", 8'hF0, 10'b1111100000, 26, 25, 3, 1'b0);
      check("rstf_tx", 32'(tx), 32'd1);
      check("rstf_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rstf_rel_tx", 32'(tx), 32'd1);
      check("rstf_rel_busy", 32'(busy), 32'd0);
      data = 8'h81; new_data = 1'b1;
      check_frame("post_rst", 8'h81, 10'b1100000010, 40, -1, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_serial_tx

// File: doc/serial_tx.md
# serial_tx

UART transmitter, 8N1, LSB first, fixed bit period of CLK_PER_BIT clocks. It is the transmit-side companion of the team's serial receiver: same bit timing, same idle-high line, same byte/strobe style. It accepts one byte per frame via a strobe-and-busy handshake and supports a flow-control `block` input from the downstream consumer (e.g. USB bridge buffer-full).

## Interface
Parameters:
- CLK_PER_BIT, 50, clocks per serial bit; legal range ≥ 2.
- CTR_SIZE, $clog2(CLK_PER_BIT), bit-period counter width (derived, not overridden).

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- tx  output  1  serial line, idle high.
- block  input  1  flow control. When high, no new frame starts.
- busy  output  1  high when a byte would not be accepted.
- data  input  8  byte to send; sampled only on the acceptance cycle.
- new_data  input  1  one-cycle strobe; byte accepted iff `new_data && !busy`.

## Operation
- Registers: state, bit-period counter `ctr` (CTR_SIZE), bit index (3b), shift register (8b), tx_q, block_q.
- `block_q` is `block` delayed one cycle.
- `busy = block_q || (state != IDLE)`, combinational from registers.
- States:
  - IDLE:
    - tx_q=1, ctr=0, bit index=0.
    - On acceptance: load shift register with `data` and go to START_BIT.
  - START_BIT:
    - tx_q=0 for CLK_PER_BIT cycles; ctr counts 0..CLK_PER_BIT-1.
    - At CLK_PER_BIT-1: ctr←0, go to DATA.
  - DATA:
    - tx_q = shift[0].
    - At ctr==CLK_PER_BIT-1: shift right, bit index+1, ctr←0.
    - After bit index 7 completes, go to STOP_BIT.
  - STOP_BIT:
    - tx_q=1 for CLK_PER_BIT cycles, then go to IDLE.
  - Illegal encoding: go to IDLE.
- `new_data` while busy is ignored. The byte is dropped and there is no error flag; senders must gate on `!busy`.
- `block` rising mid-frame does not abort the frame. The frame completes, then the block remains in IDLE with busy high until block_q falls.
- `data` changing after acceptance has no effect.
- Reset:
  - state=IDLE, tx_q=1, ctr=0, bit index=0, block_q=0.
  - busy=0 on the first cycle after reset (if `block` was low).
  - Reset mid-frame truncates the frame immediately; tx goes high on the next edge.

## Timing
- Acceptance at edge N (new_data=1, busy=0): tx falls at N+1, busy rises at N+1.
- Bit k (0..7) is driven from N+1+(k+1)·CLK_PER_BIT for CLK_PER_BIT cycles.
- Stop bit spans N+1+9·CLK_PER_BIT … N+10·CLK_PER_BIT.
- busy falls at N+1+10·CLK_PER_BIT (state back in IDLE).
- Back-to-back frames: minimum frame pitch is 10·CLK_PER_BIT+1 cycles, i.e. one extra idle-high cycle between stop and next start.
- Block timing:
  - `block` asserted at edge M makes busy high from M+1.
  - A `new_data` at edge M is still accepted if busy was low at M.
- tx is a registered output with no combinational path from inputs.

## Structure
- Single module, no sub-module; the bit counter is too small to justify splitting out.
- State localparams (IDLE=0, START_BIT=1, DATA=2, STOP_BIT=3, 2-bit) stay local to the module; no shared package.
- CLK_PER_BIT must be set from the same top-level constant that parameterises the receiver, so both ends share one baud definition.

## Test plan
All scenarios use CLK_PER_BIT=4.
- After reset, idle: tx=1, busy=0 for 20 cycles; new_data held 0.
- Send 0xA5: tx=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles. busy high exactly 40 cycles; a reference receiver model decodes 0xA5.
- Back-to-back 0x00 then 0xFF, each strobed on the first cycle busy=0: frame pitch is exactly 41 cycles and both bytes decode correctly.
- new_data pulse with data=0x3C while busy mid-frame: ignored, and the line carries only the original byte.
- `block` raised during bit 3 of a 0x55 frame: frame completes intact and busy stays high. A strobe of 0x12 while blocked is dropped. After `block` falls, busy falls 1 cycle later and 0x12 is then accepted and sent.
- rst asserted during bit 5: tx=1 the next cycle and busy=0 after release. The next byte 0x81 transmits correctly.
